modulo_product_mp: RTL and testbench



---
 rtl/modprod_pkg.sv | 33 +++
 rtl/modulo_product_mp_if.sv | 27 ++
 rtl/modprod_addmod.sv | 25 ++
 rtl/modulo_product_mp.sv | 163 ++++++++++++++++
 tb/tb_modulo_product_mp.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/modprod_pkg.sv
// modprod_pkg -- shared definitions for the modulo_product_mp modular multiplier.
//   state_t      : controller states (IDLE, RUN)
//   mode_t       : active-length codes selecting L = WIDTH/8, /4, /2 or WIDTH
//   active_bits  : maps a mode code and the maximum width to L
//   cnt_width    : iteration-counter width, $clog2(WIDTH)+1
package modprod_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_W8 = 2'b00,
    MODE_W4 = 2'b01,
    MODE_W2 = 2'b10,
    MODE_W1 = 2'b11
  } mode_t;

  function automatic int active_bits(input logic [1:0] mode, input int width);
    case (mode_t'(mode))
      MODE_W8: return width / 8;
      MODE_W4: return width / 4;
      MODE_W2: return width / 2;
      default: return width;
    endcase
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/modulo_product_mp_if.sv
// modulo_product_mp_if -- request/response bundle of the modular multiplier.
//   i_start, i_mode, i_n, i_a, i_b : job request from the controller
//   o_busy, o_result, o_finished, o_error : job status and product
// master modport: the requesting controller; slave modport: the multiplier.
interface modulo_product_mp_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic [WIDTH-1:0] o_result;
  logic             o_finished;
  logic             o_error;

  modport master (
    output i_start, i_mode, i_n, i_a, i_b,
    input  o_busy, o_result, o_finished, o_error
  );

  modport slave (
    input  i_start, i_mode, i_n, i_a, i_b,
    output o_busy, o_result, o_finished, o_error
  );
endinterface

// File: rtl/modprod_addmod.sv
// modprod_addmod -- combinational r = (x + y) mod n.
//   x, y : addends, both assumed < n
//   n    : modulus
//   r    : reduced sum
// With x, y < n the WIDTH+1-bit sum is < 2n, so one conditional subtract
// of n is an exact reduction.
module modprod_addmod #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, n}) begin
      r = WIDTH'(sum - {1'b0, n});
    end else begin
      r = sum[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/modulo_product_mp.sv
// modulo_product_mp -- bit-serial interleaved double-and-add modular
// multiplier, o_result = (a * b) mod n over the active length L selected
// by i_mode.
//   i_clk : clock, rising edge
//   i_rst : asynchronous, active-low reset
//   bus   : modulo_product_mp_if.slave (start/mode/operands in,
//           busy/result/finished/error out)
// Build option: define MODPROD_RADIX4_EN to consume two multiplier bits per
// RUN cycle (latency L/2 instead of L); results are identical.
module modulo_product_mp
  import modprod_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  modulo_product_mp_if.slave bus
);

`ifdef MODPROD_RADIX4_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [WIDTH-1:0] t_reg, t_next;
  logic [WIDTH-1:0] n_reg, n_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CW-1:0]    k_last_reg, k_last_next;
  logic             finished_reg, finished_next;
  logic             error_reg, error_next;
  // A rejected job is reported one edge after it was sampled; this flag
  // carries it across that edge while the controller stays in IDLE.
  logic             err_pend_reg, err_pend_next;

  int               active_len;
  logic [WIDTH-1:0] len_mask;
  logic [WIDTH-1:0] a_in, b_in, n_in;
  logic             bad_in;
  logic [WIDTH-1:0] m_step, t_step;

  // Request operands reduced to the active length.
  always_comb begin
    active_len = active_bits(bus.i_mode, WIDTH);
    len_mask   = {WIDTH{1'b1}} >> (WIDTH - active_len);
    a_in       = bus.i_a & len_mask;
    b_in       = bus.i_b & len_mask;
    n_in       = bus.i_n & len_mask;
    bad_in     = (n_in == '0) || (b_in >= n_in);
  end

  // Per-bit stage: conditional accumulate of t, then t doubled. Stage gi
  // consumes a_reg[gi]; the remaining multiplier bits are shifted down each
  // cycle so the stages always see the next unconsumed bits.
  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] m_in, t_in, addend, m_out, t_out;
    if (gi == 0) begin : g_first
      assign m_in = m_reg;
      assign t_in = t_reg;
    end else begin : g_chain
      assign m_in = g_stage[gi-1].m_out;
      assign t_in = g_stage[gi-1].t_out;
    end
    assign addend = a_reg[gi] ? t_in : '0;
    modprod_addmod #(.WIDTH(WIDTH)) u_acc (
      .x(m_in), .y(addend), .n(n_reg), .r(m_out)
    );
    modprod_addmod #(.WIDTH(WIDTH)) u_dbl (
      .x(t_in), .y(t_in), .n(n_reg), .r(t_out)
    );
  end

  assign m_step = g_stage[STAGES-1].m_out;
  assign t_step = g_stage[STAGES-1].t_out;

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    m_next        = m_reg;
    t_next        = t_reg;
    n_next        = n_reg;
    result_next   = result_reg;
    cnt_next      = cnt_reg;
    k_last_next   = k_last_reg;
    finished_next = 1'b0;
    error_next    = error_reg;
    err_pend_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (err_pend_reg) begin
          result_next   = '0;
          error_next    = 1'b1;
          finished_next = 1'b1;
        end else if (bus.i_start) begin
          a_next      = a_in;
          n_next      = n_in;
          k_last_next = CW'(active_len / STAGES - 1);
          if (bad_in) begin
            err_pend_next = 1'b1;
          end else begin
            m_next     = '0;
            t_next     = b_in;
            cnt_next   = '0;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        m_next   = m_step;
        t_next   = t_step;
        a_next   = a_reg >> STAGES;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == k_last_reg) begin
          result_next   = m_step;
          error_next    = 1'b0;
          finished_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      m_reg        <= '0;
      t_reg        <= '0;
      n_reg        <= '0;
      result_reg   <= '0;
      cnt_reg      <= '0;
      k_last_reg   <= '0;
      finished_reg <= 1'b0;
      error_reg    <= 1'b0;
      err_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      m_reg        <= m_next;
      t_reg        <= t_next;
      n_reg        <= n_next;
      result_reg   <= result_next;
      cnt_reg      <= cnt_next;
      k_last_reg   <= k_last_next;
      finished_reg <= finished_next;
      error_reg    <= error_next;
      err_pend_reg <= err_pend_next;
    end
  end

  assign bus.o_busy     = (state_reg == RUN);
  assign bus.o_result   = result_reg;
  assign bus.o_finished = finished_reg;
  assign bus.o_error    = error_reg;

endmodule

// File: tb/tb_modulo_product_mp.sv
// tb_modulo_product_mp -- self-checking bench for modulo_product_mp (WIDTH=256):
// directed vector table, randomized jobs against an arithmetic reference,
// start-while-busy, reset mid-run and back-to-back sequences.
module tb_modulo_product_mp;
  import modprod_pkg::*;

  localparam int W = 256;
`ifdef MODPROD_RADIX4_EN
  localparam int RAD = 2;
`else
  localparam int RAD = 1;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   fin_cyc;

  modulo_product_mp_if #(.WIDTH(W)) bus ();

  modulo_product_mp #(.WIDTH(W)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string          name;
    logic [1:0]     mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   n;
    logic [W-1:0]   r;
    logic           e;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [1:0] mode);
    return W >> (3 - int'(mode));
  endfunction

  function automatic logic [W-1:0] mask_of(input logic [1:0] mode);
    logic [W-1:0] ones;
    ones = '1;
    return ones >> (W - len_of(mode));
  endfunction

  // Reference: plain double-width multiply and modulo on the masked operands.
  function automatic void model(input logic [1:0] mode, input logic [W-1:0] a, b, n,
                                output logic [W-1:0] r, output logic e, output int k);
    logic [W-1:0]   msk, am, bm, nm;
    logic [2*W-1:0] prod;
    msk = mask_of(mode);
    am  = a & msk;
    bm  = b & msk;
    nm  = n & msk;
    e   = (nm == '0) || (bm >= nm);
    if (e) begin
      r = '0;
      k = 1;
    end else begin
      prod = {{W{1'b0}}, am} * {{W{1'b0}}, bm};
      r    = W'(prod % {{W{1'b0}}, nm});
      k    = len_of(mode) / RAD;
    end
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One job: drive request, scramble inputs after acceptance, wait (bounded)
  // for o_finished and compare latency, result, error and busy.
  task automatic run_job(input string name, input logic [1:0] mode,
                         input logic [W-1:0] a, b, n, exp_r, input logic exp_e,
                         input int exp_k, input bit b2b, input int intrude);
    int cycles;
    if (!b2b) @(negedge clk);
    bus.i_mode  = mode;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_n     = n;
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_a     = ~a;
    bus.i_b     = '1;
    bus.i_n     = '0;
    cycles      = 0;
    check({name, " busy"}, W'(bus.o_busy), W'(!exp_e));
    while (!bus.o_finished && cycles < exp_k + 20) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      bus.i_start = (cycles == intrude);
    end
    bus.i_start = 1'b0;
    fin_cyc = cyc;
    check({name, " latency"}, W'(cycles), W'(exp_k));
    check({name, " result"}, bus.o_result, exp_r);
    check({name, " error"}, W'(bus.o_error), W'(exp_e));
    check({name, " busy at end"}, W'(bus.o_busy), W'(0));
    $display("job %s mode=%0d latency=%0d result=%0h error=%0b",
             name, mode, cycles, bus.o_result, bus.o_error);
  endtask

  initial begin
    logic [W-1:0] p25519, n128, r_m, a_r, b_r, n_r, msk;
    logic         e_m;
    int           k_m, t1, seen;

    n_checks = 0;
    n_errors = 0;
    fin_cyc  = 0;

    p25519 = (W'(1) << 255) - W'(19);
    n128   = (W'(1) << 128) - W'(159);
    vecs[0] = '{"small",    MODE_W8, W'(13), W'(29), W'(97), W'(86), 1'b0};
    vecs[1] = '{"full",     MODE_W1, p25519 - W'(1), p25519 - W'(1), p25519, W'(1), 1'b0};
    vecs[2] = '{"masking",  MODE_W8, W'(64'hFFFFFFFF_00000005),
                (W'(16'hDEAD) << 64) | W'(3), (W'(16'hBEEF) << 100) | W'(11), W'(4), 1'b0};
    vecs[3] = '{"err n0",   MODE_W4, W'(5), W'(0), W'(1) << 100, W'(0), 1'b1};
    vecs[4] = '{"err b=n",  MODE_W8, W'(3), W'(7), W'(7), W'(0), 1'b1};
    vecs[5] = '{"mode01",   MODE_W4, (W'(1) << 200) | W'(12345), W'(678), W'(1000003),
                W'(369886), 1'b0};
    vecs[6] = '{"mode10",   MODE_W2, W'(2), n128 - W'(1), n128, n128 - W'(2), 1'b0};
    vecs[7] = '{"n=1",      MODE_W8, W'(32'hFFFFFFFF), W'(0), W'(1), W'(0), 1'b0};

    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_mode  = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_n     = '0;
    repeat (3) @(negedge clk);
    check("reset result", bus.o_result, W'(0));
    check("reset busy", W'(bus.o_busy), W'(0));
    check("reset finished", W'(bus.o_finished), W'(0));
    check("reset error", W'(bus.o_error), W'(0));
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].n,
              vecs[i].r, vecs[i].e,
              vecs[i].e ? 1 : len_of(vecs[i].mode) / RAD, 1'b0, -1);
      @(negedge clk);
      check({vecs[i].name, " pulse width"}, W'(bus.o_finished), W'(0));
    end

    // Randomized jobs against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [1:0] md;
      md  = 2'($urandom_range(0, 3));
      msk = mask_of(md);
      a_r = rand_w();
      n_r = rand_w() >> $urandom_range(0, 200);
      b_r = rand_w();
      if ($urandom_range(0, 9) < 8 && (n_r & msk) != '0)
        b_r = (b_r & ~msk) | (rand_w() % (n_r & msk));
      model(md, a_r, b_r, n_r, r_m, e_m, k_m);
      run_job($sformatf("rand%0d", i), md, a_r, b_r, n_r, r_m, e_m, k_m, 1'b0, -1);
    end

    // Start pulsed mid-RUN is ignored.
    run_job("start while busy", vecs[0].mode, vecs[0].a, vecs[0].b, vecs[0].n,
            vecs[0].r, 1'b0, len_of(vecs[0].mode) / RAD, 1'b0, 5);

    // Reset mid-RUN: immediate abort, no finished pulse afterwards.
    @(negedge clk);
    bus.i_mode  = vecs[1].mode;
    bus.i_a     = vecs[1].a;
    bus.i_b     = vecs[1].b;
    bus.i_n     = vecs[1].n;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun busy", W'(bus.o_busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrun reset result", bus.o_result, W'(0));
    check("midrun reset busy", W'(bus.o_busy), W'(0));
    check("midrun reset finished", W'(bus.o_finished), W'(0));
    check("midrun reset error", W'(bus.o_error), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_finished) seen = 1;
    end
    check("no finish after reset", W'(seen), W'(0));
    run_job("after reset", vecs[2].mode, vecs[2].a, vecs[2].b, vecs[2].n,
            vecs[2].r, 1'b0, len_of(vecs[2].mode) / RAD, 1'b0, -1);

    // Back-to-back: second start in the o_finished cycle.
    run_job("b2b first", vecs[0].mode, vecs[0].a, vecs[0].b, vecs[0].n,
            vecs[0].r, 1'b0, len_of(vecs[0].mode) / RAD, 1'b0, -1);
    t1 = fin_cyc;
    run_job("b2b second", vecs[2].mode, vecs[2].a, vecs[2].b, vecs[2].n,
            vecs[2].r, 1'b0, len_of(vecs[2].mode) / RAD, 1'b1, -1);
    check("b2b gap", W'(fin_cyc - t1), W'(len_of(vecs[2].mode) / RAD + 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
